// File: rtl/ddr_arbiter.sv
// ddr_arbiter: shares one DDR burst port between I-cache reads, D-cache reads
// and D-cache stores, with starvation protection for instruction fetch.
module ddr_arbiter #(
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int DATA_WIDTH     = 16,
   parameter int BURST_LEN      = 16,
   parameter int STARVE_MAX     = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      INSTR_read_req,
   input  logic [DDR_ADDR_WIDTH-1:0] INSTR_read_addr,
   input  logic                      DATA_read_req,
   input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
   input  logic                      DATA_store_req,
   input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
   input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
   output logic [9:0]                rd_cnt_instr,
   output logic [9:0]                rd_cnt_data,
   output logic [DATA_WIDTH-1:0]     INSTR_to_cache,
   output logic [DATA_WIDTH-1:0]     DATA_to_cache,
   output logic                      rd_burst_data_valid_instr,
   output logic                      rd_burst_data_valid_data,
   output logic                      wr_burst_data_req,
   output logic [3:0]                state_interface_module,
   output logic                      rd_burst_req,
   output logic                      wr_burst_req,
   output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
   output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
   output logic [9:0]                rd_burst_len,
   output logic [9:0]                wr_burst_len,
   input  logic [DATA_WIDTH-1:0]     rd_burst_data,
   input  logic                      rd_burst_data_valid,
   input  logic                      rd_burst_finish,
   input  logic                      ddr_wr_data_req,
   output logic [DATA_WIDTH-1:0]     wr_burst_data,
   input  logic                      wr_burst_finish
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_RD_I = 4'd7;
   localparam logic [3:0] S_RD_D = 4'd8;
   localparam logic [3:0] S_WR   = 4'd9;
   localparam logic [3:0] S_REL  = 4'd10;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
   localparam logic [9:0] CNT_MAX    = 10'h3FF;

   logic [3:0]                state_q, state_d;
   logic [3:0]                srv_q, srv_d;
   logic [7:0]                starve_q, starve_d, starve_nxt;
   logic                      rd_req_q, rd_req_d;
   logic                      wr_req_q, wr_req_d;
   logic [DDR_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [DDR_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [9:0]                cnt_i_q, cnt_i_d;
   logic [9:0]                cnt_d_q, cnt_d_d;
   logic                      instr_win, srv_req;
   logic                      in_rd_i, in_rd_d, in_wr;

   // Instruction wins outright once starved, otherwise only when alone.
   assign instr_win = INSTR_read_req &&
                      (starve_q == STARVE_LIM ||
                       (!DATA_store_req && !DATA_read_req));

   assign starve_nxt = !INSTR_read_req          ? 8'd0     :
                       (starve_q == STARVE_LIM) ? starve_q :
                                                  starve_q + 8'd1;

   assign srv_req = (srv_q == S_RD_I && INSTR_read_req) ||
                    (srv_q == S_RD_D && DATA_read_req)  ||
                    (srv_q == S_WR   && DATA_store_req);

   always_comb begin
      state_d   = state_q;
      srv_d     = srv_q;
      starve_d  = starve_q;
      rd_req_d  = rd_req_q;
      wr_req_d  = wr_req_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      cnt_i_d   = cnt_i_q;
      cnt_d_d   = cnt_d_q;
      unique case (state_q)
         S_IDLE: begin
            if (!INSTR_read_req) starve_d = 8'd0;
            if (instr_win) begin
               state_d   = S_RD_I;
               rd_req_d  = 1'b1;
               rd_addr_d = INSTR_read_addr;
               cnt_i_d   = 10'd0;
               starve_d  = 8'd0;
            end else if (DATA_store_req) begin
               state_d   = S_WR;
               wr_req_d  = 1'b1;
               wr_addr_d = DATA_write_addr;
               starve_d  = starve_nxt;
            end else if (DATA_read_req) begin
               state_d   = S_RD_D;
               rd_req_d  = 1'b1;
               rd_addr_d = DATA_read_addr;
               cnt_d_d   = 10'd0;
               starve_d  = starve_nxt;
            end
         end
         S_RD_I: begin
            if (rd_burst_data_valid && cnt_i_q != CNT_MAX)
               cnt_i_d = cnt_i_q + 10'd1;
            if (rd_burst_finish) begin
               state_d  = S_REL;
               srv_d    = state_q;
               rd_req_d = 1'b0;
            end
         end
         S_RD_D: begin
            if (rd_burst_data_valid && cnt_d_q != CNT_MAX)
               cnt_d_d = cnt_d_q + 10'd1;
            if (rd_burst_finish) begin
               state_d  = S_REL;
               srv_d    = state_q;
               rd_req_d = 1'b0;
            end
         end
         S_WR: begin
            if (wr_burst_finish) begin
               state_d  = S_REL;
               srv_d    = state_q;
               wr_req_d = 1'b0;
            end
         end
         S_REL: begin
            // Hold until the served level request drops.
            if (!srv_req) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         srv_q     <= S_IDLE;
         starve_q  <= 8'd0;
         rd_req_q  <= 1'b0;
         wr_req_q  <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         cnt_i_q   <= 10'd0;
         cnt_d_q   <= 10'd0;
      end else begin
         state_q   <= state_d;
         srv_q     <= srv_d;
         starve_q  <= starve_d;
         rd_req_q  <= rd_req_d;
         wr_req_q  <= wr_req_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         cnt_i_q   <= cnt_i_d;
         cnt_d_q   <= cnt_d_d;
      end
   end

   assign in_rd_i = (state_q == S_RD_I);
   assign in_rd_d = (state_q == S_RD_D);
   assign in_wr   = (state_q == S_WR);

   assign state_interface_module    = state_q;
   assign rd_burst_req              = rd_req_q;
   assign wr_burst_req              = wr_req_q;
   assign rd_burst_addr             = rd_addr_q;
   assign wr_burst_addr             = wr_addr_q;
   assign rd_burst_len              = 10'(BURST_LEN);
   assign wr_burst_len              = 10'(BURST_LEN);
   assign rd_cnt_instr              = cnt_i_q;
   assign rd_cnt_data               = cnt_d_q;
   assign INSTR_to_cache            = in_rd_i ? rd_burst_data : '0;
   assign DATA_to_cache             = in_rd_d ? rd_burst_data : '0;
   assign rd_burst_data_valid_instr = in_rd_i & rd_burst_data_valid;
   assign rd_burst_data_valid_data  = in_rd_d & rd_burst_data_valid;
   assign wr_burst_data_req         = in_wr & ddr_wr_data_req;
   assign wr_burst_data             = in_wr ? DATA_to_ddr : '0;

endmodule
